// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR) with valid/ready stages and flush.
// Define SHIFT_UNIT_ROTATE_EN to make ROL (011) and ROR (100) legal.
module shift_unit_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_EVERY = 1,
    parameter int unsigned TAG_W     = 5
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_flush,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [2:0]              i_op,
    input  logic [XLEN-1:0]         i_operand,
    input  logic [$clog2(XLEN)-1:0] i_shamt,
    input  logic [TAG_W-1:0]        i_tag,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [XLEN-1:0]         o_data,
    output logic [TAG_W-1:0]        o_tag,
    output logic                    o_illegal
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned LAT = (SHW + REG_EVERY - 1) / REG_EVERY;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    typedef struct packed {
        logic [2:0]       op;
        logic             sign;
        logic [SHW-1:0]   shamt;
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } stage_t;

    logic [LAT-1:0]  valid_q, valid_d;
    logic [LAT-1:0]  ready;
    stage_t          stage_q [LAT];
    stage_t          stage_d [LAT];
    stage_t          in_stage;
    logic [XLEN-1:0] shifted [LAT];
    logic            in_illegal;

    function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] d, input logic [2:0] op,
                                                    input logic sign, input int unsigned n);
        logic [XLEN-1:0] ones;
        ones = '1;
        case (op_e'(op))
            OP_SLL:  return d << n;
            OP_SRL:  return d >> n;
            OP_SRA:  return (d >> n) | ({XLEN{sign}} & ~(ones >> n));
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROL:  return (d << n) | (d >> (XLEN - n));
            OP_ROR:  return (d >> n) | (d << (XLEN - n));
`endif
            default: return d;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] stage_shift(input logic [XLEN-1:0] d, input logic [2:0] op,
                                                    input logic sign, input logic [SHW-1:0] shamt,
                                                    input int unsigned lo, input int unsigned hi);
        logic [XLEN-1:0] r;
        r = d;
        for (int unsigned k = 0; k < SHW; k++) begin
            if (k >= lo && k < hi && shamt[k]) r = shift_level(r, op, sign, 32'd1 << k);
        end
        return r;
    endfunction

    // Each register sits in front of its group of shift levels, so the
    // output levels are driven from the last register, never from i_operand.
    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int unsigned LO = s * REG_EVERY;
        localparam int unsigned HI = (LO + REG_EVERY > SHW) ? SHW : LO + REG_EVERY;
        assign shifted[s] = stage_shift(stage_q[s].data, stage_q[s].op, stage_q[s].sign,
                                        stage_q[s].shamt, LO, HI);
    end

    always_comb begin
`ifdef SHIFT_UNIT_ROTATE_EN
        in_illegal = i_op > 3'b100;
`else
        in_illegal = i_op > 3'b010;
`endif
        in_stage.op      = i_op;
        in_stage.sign    = !in_illegal && i_operand[XLEN-1];
        in_stage.shamt   = i_shamt;
        in_stage.data    = in_illegal ? '0 : i_operand;
        in_stage.tag     = i_tag;
        in_stage.illegal = in_illegal;
    end

    always_comb begin : ready_chain
        logic full;
        full  = 1'b1;
        ready = '0;
        for (int unsigned s = LAT; s > 0; s--) begin
            full       = full && valid_q[s-1];
            ready[s-1] = i_ready || !full;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        stage_d[0] = stage_q[0];
        if (ready[0]) begin
            valid_d[0] = i_valid;
            if (i_valid) stage_d[0] = in_stage;
        end
        for (int unsigned s = 1; s < LAT; s++) begin
            stage_d[s] = stage_q[s];
            if (ready[s]) begin
                valid_d[s] = valid_q[s-1];
                if (valid_q[s-1]) begin
                    stage_d[s]      = stage_q[s-1];
                    stage_d[s].data = shifted[s-1];
                end
            end
        end
        if (i_flush) valid_d = '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= '0;
            for (int unsigned s = 0; s < LAT; s++) stage_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int unsigned s = 0; s < LAT; s++) stage_q[s] <= stage_d[s];
        end
    end

    assign o_ready   = ready[0];
    assign o_valid   = valid_q[LAT-1];
    assign o_data    = shifted[LAT-1];
    assign o_tag     = stage_q[LAT-1].tag;
    assign o_illegal = stage_q[LAT-1].illegal;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: directed latency/stall/flush/reset cases plus random traffic.
module tb_shift_unit_pipe #(
    parameter int unsigned REG_EVERY = 1
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned SHW  = 5;
    localparam int unsigned LAT  = (SHW + REG_EVERY - 1) / REG_EVERY;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        ill;
        int unsigned cyc;
    } exp_t;

    logic        i_clk, i_reset, i_flush, i_valid, o_ready, o_valid, i_ready, o_illegal;
    logic [2:0]  i_op;
    logic [31:0] i_operand, o_data;
    logic [4:0]  i_shamt, i_tag, o_tag;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    logic        lat_chk = 1'b1;
    exp_t        exp_q [$];
    exp_t        got_q [$];
    logic        stall_prev = 1'b0, flush_prev = 1'b0;
    logic [31:0] held_data;
    logic [4:0]  held_tag;

    shift_unit_pipe #(.XLEN(XLEN), .REG_EVERY(REG_EVERY), .TAG_W(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_operand(i_operand), .i_shamt(i_shamt), .i_tag(i_tag), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag), .o_illegal(o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                                   input logic [4:0] tag);
        exp_t e;
        e.tag = tag; e.ill = 1'b0; e.data = '0; e.cyc = cyc;
        case (op)
            3'd0: e.data = a << sh;
            3'd1: e.data = a >> sh;
            3'd2: e.data = $signed(a) >>> sh;
`ifdef SHIFT_UNIT_ROTATE_EN
            3'd3: e.data = (a << sh) | (a >> (32 - sh));
            3'd4: e.data = (a >> sh) | (a << (32 - sh));
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: output pop first, then flush/reset clear, then input push.
    always @(negedge i_clk) begin
        if (i_reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
            flush_prev = 1'b0;
        end else begin
            if (stall_prev && !flush_prev) begin
                check_eq("hold_valid", o_valid, 1);
                check_eq("hold_data", o_data, held_data);
                check_eq("hold_tag", o_tag, held_tag);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check_eq("unexp_out", exp_q.size(), 1);
                else begin
                    exp_t e, g;
                    e = exp_q.pop_front();
                    check_eq("data", o_data, e.data);
                    check_eq("tag", o_tag, e.tag);
                    check_eq("illegal", o_illegal, e.ill);
                    if (lat_chk) check_eq("latency", cyc - e.cyc, LAT);
                    g.data = o_data; g.tag = o_tag; g.ill = o_illegal; g.cyc = cyc;
                    got_q.push_back(g);
                end
            end
            if (i_flush) exp_q.delete();
            else if (i_valid && o_ready) exp_q.push_back(model(i_op, i_operand, i_shamt, i_tag));
            stall_prev = o_valid && !i_ready;
            flush_prev = i_flush;
            held_data  = o_data;
            held_tag   = o_tag;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                        input logic [4:0] tag);
        logic acc;
        acc = 1'b0;
        i_valid = 1'b1; i_op = op; i_operand = a; i_shamt = sh; i_tag = tag;
        for (int n = 0; n < 100; n++) begin
            @(negedge i_clk);
            acc = o_ready;
            tick();
            if (acc) return;
        end
        check_eq("send_timeout", acc, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge i_clk);
            #1;
            if (exp_q.size() == 0 && !o_valid) break;
        end
        check_eq("drain", exp_q.size(), 0);
        tick();
    endtask

    task automatic expect_log(input string name, input logic [31:0] data, input logic [4:0] tag,
                              input logic ill);
        exp_t g;
        if (got_q.size() == 0) begin
            check_eq({name, "_present"}, got_q.size(), 1);
            return;
        end
        g = got_q.pop_front();
        check_eq({name, "_data"}, g.data, data);
        check_eq({name, "_tag"}, g.tag, tag);
        check_eq({name, "_ill"}, g.ill, ill);
    endtask

    initial begin
        int unsigned acc, t;
        exp_t g, p;
        i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_op = '0; i_operand = '0; i_shamt = '0; i_tag = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        #1 i_reset = 1'b0;
        check_eq("rst_ovalid", o_valid, 0);
        check_eq("rst_odata", o_data, 0);
        check_eq("rst_otag", o_tag, 0);
        check_eq("rst_oill", o_illegal, 0);
        check_eq("rst_oready", o_ready, 1);
        tick();

        // Basic shifts, in-order tags, latency checked by the scoreboard
        send(3'b010, 32'h8000_0000, 5'd31, 5'd1);
        send(3'b001, 32'h8000_0000, 5'd31, 5'd2);
        send(3'b000, 32'h0000_0001, 5'd31, 5'd3);
        i_valid = 1'b0;
        drain();
        expect_log("sra31", 32'hFFFF_FFFF, 5'd1, 1'b0);
        expect_log("srl31", 32'h0000_0001, 5'd2, 1'b0);
        expect_log("sll31", 32'h8000_0000, 5'd3, 1'b0);

        send(3'b100, 32'h0000_00F1, 5'd4, 5'd4);
        send(3'b011, 32'h8000_0001, 5'd1, 5'd5);
        send(3'b111, 32'h1234_5678, 5'd3, 5'd6);
        for (int op = 0; op < 3; op++) send(3'(op), 32'hDEAD_BEEF, 5'd0, 5'd7);
        i_valid = 1'b0;
        drain();
`ifdef SHIFT_UNIT_ROTATE_EN
        expect_log("ror4", 32'h1000_000F, 5'd4, 1'b0);
        expect_log("rol1", 32'h0000_0003, 5'd5, 1'b0);
`else
        expect_log("ror4", 32'h0, 5'd4, 1'b1);
        expect_log("rol1", 32'h0, 5'd5, 1'b1);
`endif
        expect_log("op111", 32'h0, 5'd6, 1'b1);
        for (int i = 0; i < 3; i++) expect_log("shamt0", 32'hDEAD_BEEF, 5'd7, 1'b0);

        // Back-to-back: one result per cycle
        got_q.delete();
        for (int unsigned k = 8; k < 16; k++) send(3'(k % 3), $urandom, 5'(k), 5'(k));
        i_valid = 1'b0;
        drain();
        check_eq("b2b_count", got_q.size(), 8);
        for (int i = 1; i < got_q.size(); i++) check_eq("b2b_gap", got_q[i].cyc - got_q[i-1].cyc, 1);

        // Stall: capacity LAT, outputs held stable while i_ready is low
        got_q.delete();
        lat_chk = 1'b0;
        i_ready = 1'b0;
        acc = 0; t = 16;
        for (int unsigned c = 0; c <= LAT; c++) begin
            i_valid = 1'b1; i_op = 3'(t % 3); i_operand = 32'h0101_0101 * t;
            i_shamt = 5'(t); i_tag = 5'(t);
            @(negedge i_clk);
            if (o_ready) begin acc++; t++; end
            tick();
        end
        i_valid = 1'b0;
        check_eq("stall_accepted", acc, LAT);
        @(negedge i_clk);
        check_eq("stall_oready", o_ready, 0);
        tick();
        tick();
        i_ready = 1'b1;
        drain();
        lat_chk = 1'b1;
        check_eq("stall_count", got_q.size(), LAT);
        for (int i = 0; i < got_q.size(); i++) check_eq("stall_order", got_q[i].tag, 16 + i);

        // Flush with ops in flight and an input in the same cycle
        got_q.delete();
        send(3'b000, 32'h0000_0011, 5'd2, 5'd24);
        send(3'b001, 32'h0000_0022, 5'd3, 5'd25);
        send(3'b010, 32'h8000_0033, 5'd4, 5'd26);
        i_op = 3'b000; i_operand = 32'h55; i_shamt = 5'd1; i_tag = 5'd27; i_flush = 1'b1;
        @(negedge i_clk);
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        for (int unsigned c = 0; c <= LAT; c++) begin
            @(negedge i_clk);
            check_eq("flush_ovalid", o_valid, 0);
        end
        tick();
        send(3'b010, 32'hF000_0000, 5'd8, 5'd28);
        i_valid = 1'b0;
        drain();
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i].tag == 5'd27) check_eq("flushed_tag", got_q[i].tag, 28);
        expect_log("post_flush", 32'hFFF0_0000, 5'd28, 1'b0);
        if (got_q.size() != 0) check_eq("post_flush_extra", got_q.size(), 0);

        // Asynchronous reset while a result is on the output
        send(3'b000, 32'h0000_0001, 5'd5, 5'd29);
        send(3'b001, 32'hFFFF_0000, 5'd6, 5'd29);
        send(3'b010, 32'h8000_0000, 5'd7, 5'd29);
        i_valid = 1'b0;
        acc = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (o_valid) begin acc = 1; break; end
        end
        check_eq("rst_wait_ovalid", acc, 1);
        #1 i_reset = 1'b1;
        #1;
        check_eq("mrst_ovalid", o_valid, 0);
        check_eq("mrst_odata", o_data, 0);
        check_eq("mrst_otag", o_tag, 0);
        check_eq("mrst_oill", o_illegal, 0);
        @(posedge i_clk);
        @(negedge i_clk);
        #1 i_reset = 1'b0;
        check_eq("mrst_oready", o_ready, 1);
        got_q.delete();
        tick();
        send(3'b001, 32'h0000_00F0, 5'd4, 5'd30);
        i_valid = 1'b0;
        drain();
        expect_log("post_reset", 32'h0000_000F, 5'd30, 1'b0);

        // Random traffic with random back-pressure
        lat_chk = 1'b0;
        acc = 0;
        for (int c = 0; c < 20000 && acc < 1000; c++) begin
            i_valid   = $urandom_range(0, 3) != 0;
            i_op      = 3'($urandom_range(0, 7));
            i_operand = $urandom;
            i_shamt   = 5'($urandom);
            i_tag     = 5'($urandom);
            i_ready   = $urandom_range(0, 3) != 0;
            @(negedge i_clk);
            if (i_valid && o_ready) acc++;
            tick();
        end
        check_eq("rand_accepted", acc, 1000);
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
# shift_unit_pipe

Parametrised, pipelined barrel shifter for the execute stage. Performs logical left, logical right and arithmetic right shifts, plus optional rotates, on an XLEN-bit operand. Shift levels are split into register stages with a valid/ready elastic handshake, flush support and a sideband tag. Sits beside the ALU and replaces the fixed 32-bit combinational arithmetic-right shifter.

## Interface
- XLEN, 32, operand width; power of two, 8..64
- REG_EVERY, 1, shift levels (1,2,4,...) per pipeline register; LAT = ceil(log2(XLEN)/REG_EVERY)
- TAG_W, 5, width of sideband tag (e.g. rd index)
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset; asynchronous and active-high
- i_flush  in  1  synchronous kill of all in-flight operations
- i_valid  in  1  input operation valid
- o_ready  out  1  unit can accept input this cycle
- i_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; others illegal
- i_operand  in  XLEN  value to shift
- i_shamt  in  log2(XLEN)  shift amount, unsigned
- i_tag  in  TAG_W  carried unchanged to output
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_data  out  XLEN  shift result
- o_tag  out  TAG_W  tag of the result
- o_illegal  out  1  op code not supported in this build; o_data = 0

## Operation
- Shift levels k = 0..log2(XLEN)-1 shift by 2^k when i_shamt[k] = 1, LSB level first.
- SLL: zero fill from LSB. SRL: zero fill from MSB. SRA: fill with operand[XLEN-1] as sampled at entry (sign captured in stage 0, not recomputed from intermediate value).
- ROL/ROR: vacated bits filled with bits shifted out (only with macro, see Configuration).
- i_shamt = 0: o_data = i_operand for every legal op.
- Each stage s holds {valid_s, op, sign, shamt remainder, data, tag, illegal}. Stage s advances when ready_s = !valid_s || ready_(s+1); last stage ready = i_ready.
- o_ready = ready of stage 0 (combinational from i_ready through stage valids); full throughput of one op per cycle when i_ready = 1.
- Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
- Held stages keep data stable; o_data/o_tag stable while o_valid && !i_ready.
- Order preserved; no op dropped or duplicated except by flush/reset.
- i_flush: all valid_s cleared at next edge; an input presented in the flush cycle is discarded; an output handshake in the flush cycle still completes.
- Illegal op: travels pipeline normally, exits with o_illegal = 1, o_data = 0, its tag intact.

## Timing
- Latency LAT cycles from accepted input to o_valid with i_ready held high (XLEN=32: REG_EVERY=1 -> 5, 2 -> 3, 8 -> 1).
- No combinational path i_operand -> o_data; only i_ready -> o_ready is combinational.
- Capacity LAT ops; with i_ready low, o_ready drops after LAT ops accepted.
- Reset: all valid_s = 0, o_valid = 0, o_data = 0, o_tag = 0, o_illegal = 0, o_ready = 1 once reset deasserts; reset mid-operation discards all in-flight ops.
- Flush and reset both asserted: reset dominates (identical end state).

## Configuration
- SHIFT_UNIT_ROTATE_EN defined: ROL (011) and ROR (100) legal and computed; only 101-111 illegal.
- Not defined: 011-111 illegal (o_illegal = 1, o_data = 0); rotate fill logic absent.

## Test plan
- XLEN=32, REG_EVERY=1: SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF; SRL same -> 0x0000_0001; SLL 0x0000_0001 by 31 -> 0x8000_0000; each o_valid exactly 5 cycles after accept, tags 1,2,3 in order.
- Back-to-back 8 ops with i_ready = 1 -> one result per cycle; then i_ready low 6 cycles -> o_ready low after 5 accepted, outputs stable, all 8 results delivered in order when i_ready returns.
- Flush with 3 ops in flight plus i_valid in same cycle -> o_valid stays 0 next cycles, no result with those tags ever appears; op after flush completes normally.
- Assert i_reset mid-stream with o_valid = 1 -> o_valid, o_data, o_tag, o_illegal = 0 immediately; first post-reset op 0x0000_00F0 SRL 4 -> 0x0000_000F.
- Macro on: ROR 0x0000_00F1 by 4 -> 0x1000_000F; ROL 0x8000_0001 by 1 -> 0x0000_0003. Macro off: same ops -> o_illegal = 1, o_data = 0; op 111 -> illegal in both builds.
- Sweep REG_EVERY = 1,2,5 with 1000 random ops vs. reference model, random i_ready -> all match, latency = LAT.
